// File: rtl/harris_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : harris_frame_sequencer_if
// Brief    : Source handshake plus detector pixel bus of the frame sequencer.
// Revision : 1.0
// ============================================================================
interface harris_frame_sequencer_if #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) ();
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [7:0]    src_pixel;
   logic          src_valid;
   logic          src_ready;
   logic [7:0]    pixel;
   logic          pixel_valid;
   logic          sof;
   logic          eol;
   logic          eof;
   logic          flushing;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // master: the sequencer, which drives the detector-side pixel bus
   modport master (
      input  src_pixel, src_valid,
      output src_ready,
      output pixel, pixel_valid, sof, eol, eof, flushing, col, row
   );

   modport slave (
      output src_pixel, src_valid,
      input  src_ready,
      input  pixel, pixel_valid, sof, eol, eof, flushing, col, row
   );
endinterface
`default_nettype wire

// File: rtl/harris_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : harris_frame_sequencer
// Brief    : Streams one IMG_W x IMG_H frame into harrisDetector, then flushes.
// Revision : 1.0
// ============================================================================
module harris_frame_sequencer #(
   parameter int IMG_W        = 256,
   parameter int IMG_H        = 256,
   parameter int FLUSH_CYCLES = 516
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   harris_frame_sequencer_if.master  bus,
   output logic                      busy,
   output logic                      frame_done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FLUSH  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_col_q, cnt_col_d;
   logic [RW-1:0] cnt_row_q, cnt_row_d;
   logic [FW-1:0] flush_q, flush_d;
   logic [7:0]    pixel_q, pixel_d;
   logic          valid_q, valid_d;
   logic          sof_q, sof_d;
   logic          eol_q, eol_d;
   logic          eof_q, eof_d;
   logic          flushing_q, flushing_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          done_q, done_d;
   logic          accept;
   logic          last_col;
   logic          last_row;

   assign bus.src_ready = (state_q == S_STREAM);
   // A beat offered in the abort cycle is dropped, never forwarded.
   assign accept   = bus.src_valid & bus.src_ready & ~abort;
   assign last_col = (cnt_col_q == COL_LAST);
   assign last_row = (cnt_row_q == ROW_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_col_d  = cnt_col_q;
      cnt_row_d  = cnt_row_q;
      flush_d    = flush_q;
      pixel_d    = pixel_q;
      col_d      = col_q;
      row_d      = row_q;
      valid_d    = 1'b0;
      sof_d      = 1'b0;
      eol_d      = 1'b0;
      eof_d      = 1'b0;
      flushing_d = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_STREAM;
               cnt_col_d = '0;
               cnt_row_d = '0;
            end
         end
         S_STREAM: begin
            if (accept) begin
               pixel_d = bus.src_pixel;
               valid_d = 1'b1;
               col_d   = cnt_col_q;
               row_d   = cnt_row_q;
               sof_d   = (cnt_col_q == '0) && (cnt_row_q == '0);
               eol_d   = last_col;
               eof_d   = last_col && last_row;
               if (last_col) begin
                  cnt_col_d = '0;
                  if (last_row) begin
                     state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_DONE;
                     flush_d = FLUSH_LOAD;
                  end else begin
                     cnt_row_d = cnt_row_q + RW'(1);
                  end
               end else begin
                  cnt_col_d = cnt_col_q + CW'(1);
               end
            end
         end
         S_FLUSH: begin
            pixel_d    = 8'd0;
            valid_d    = 1'b1;
            flushing_d = 1'b1;
            flush_d    = flush_q - FW'(1);
            if (flush_q == FW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         cnt_col_d  = '0;
         cnt_row_d  = '0;
         flush_d    = '0;
         col_d      = '0;
         row_d      = '0;
         valid_d    = 1'b0;
         sof_d      = 1'b0;
         eol_d      = 1'b0;
         eof_d      = 1'b0;
         flushing_d = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_col_q  <= '0;
         cnt_row_q  <= '0;
         flush_q    <= '0;
         pixel_q    <= '0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eol_q      <= 1'b0;
         eof_q      <= 1'b0;
         flushing_q <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_col_q  <= cnt_col_d;
         cnt_row_q  <= cnt_row_d;
         flush_q    <= flush_d;
         pixel_q    <= pixel_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eol_q      <= eol_d;
         eof_q      <= eof_d;
         flushing_q <= flushing_d;
         col_q      <= col_d;
         row_q      <= row_d;
         done_q     <= done_d;
      end
   end

   assign bus.pixel       = pixel_q;
   assign bus.pixel_valid = valid_q;
   assign bus.sof         = sof_q;
   assign bus.eol         = eol_q;
   assign bus.eof         = eof_q;
   assign bus.flushing    = flushing_q;
   assign bus.col         = col_q;
   assign bus.row         = row_q;
   assign busy            = (state_q != S_IDLE);
   assign frame_done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_harris_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_harris_frame_sequencer
// Brief    : Randomized scoreboard bench; DUT0 flushes 5 cycles, DUT1 flushes 0.
// Revision : 1.0
// ============================================================================
module tb_harris_frame_sequencer;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int CB = $clog2(W);
   localparam int RB = $clog2(H);

   typedef struct {
      logic [7:0]    pix;
      logic [CB-1:0] col;
      logic [RB-1:0] row;
      logic          sof, eol, eof, fl;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst[2], st[2], ab[2], sv[2];
   logic [7:0]    sp[2];
   logic          rdy[2], pv[2], sofo[2], eolo[2], eofo[2], flo[2], busy[2], done[2];
   logic [7:0]    pxo[2];
   logic [CB-1:0] colo[2];
   logic [RB-1:0] rowo[2];

   harris_frame_sequencer_if #(.IMG_W(W), .IMG_H(H)) bus0 ();
   harris_frame_sequencer_if #(.IMG_W(W), .IMG_H(H)) bus1 ();

   assign bus0.src_valid = sv[0];
   assign bus0.src_pixel = sp[0];
   assign bus1.src_valid = sv[1];
   assign bus1.src_pixel = sp[1];
   assign rdy[0] = bus0.src_ready;   assign rdy[1] = bus1.src_ready;
   assign pv[0]  = bus0.pixel_valid; assign pv[1]  = bus1.pixel_valid;
   assign pxo[0] = bus0.pixel;       assign pxo[1] = bus1.pixel;
   assign colo[0] = bus0.col;        assign colo[1] = bus1.col;
   assign rowo[0] = bus0.row;        assign rowo[1] = bus1.row;
   assign sofo[0] = bus0.sof;        assign sofo[1] = bus1.sof;
   assign eolo[0] = bus0.eol;        assign eolo[1] = bus1.eol;
   assign eofo[0] = bus0.eof;        assign eofo[1] = bus1.eof;
   assign flo[0]  = bus0.flushing;   assign flo[1]  = bus1.flushing;

   harris_frame_sequencer #(.IMG_W(W), .IMG_H(H), .FLUSH_CYCLES(5)) u_dut0 (
      .clk(clk), .reset(rst[0]), .start(st[0]), .abort(ab[0]),
      .bus(bus0.master), .busy(busy[0]), .frame_done(done[0])
   );

   harris_frame_sequencer #(.IMG_W(W), .IMG_H(H), .FLUSH_CYCLES(0)) u_dut1 (
      .clk(clk), .reset(rst[1]), .start(st[1]), .abort(ab[1]),
      .bus(bus1.master), .busy(busy[1]), .frame_done(done[1])
   );

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t eq[2][$];
   int   dq[2][$];
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;

   function automatic int flush_of(input int d);
      return (d == 0) ? 5 : 0;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a DUT presents a pixel or a done pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            if (pv[d] === 1'b1) begin
               checks++;
               if (eq[d].size() == 0) begin
                  failures++;
                  $display("FAIL extra_pixel dut%0d cyc=%0d got pix=%0h", d, cyc, pxo[d]);
               end else begin
                  exp_t e;
                  e = eq[d].pop_front();
                  if ({pxo[d], colo[d], rowo[d], sofo[d], eolo[d], eofo[d], flo[d]} !==
                      {e.pix, e.col, e.row, e.sof, e.eol, e.eof, e.fl} || cyc != e.due) begin
                     failures++;
                     $display("FAIL pixel dut%0d got pix=%0h c=%0d r=%0d sof=%b eol=%b eof=%b fl=%b cyc=%0d exp pix=%0h c=%0d r=%0d sof=%b eol=%b eof=%b fl=%b cyc=%0d",
                              d, pxo[d], colo[d], rowo[d], sofo[d], eolo[d], eofo[d], flo[d], cyc,
                              e.pix, e.col, e.row, e.sof, e.eol, e.eof, e.fl, e.due);
                  end
               end
            end else begin
               while (eq[d].size() > 0 && eq[d][0].due <= cyc) begin
                  checks++;
                  failures++;
                  $display("FAIL missing_pixel dut%0d cyc=%0d got valid=0 exp pix=%0h due=%0d",
                           d, cyc, eq[d][0].pix, eq[d][0].due);
                  void'(eq[d].pop_front());
               end
            end
            if (done[d] === 1'b1) begin
               checks++;
               if (dq[d].size() == 0) begin
                  failures++;
                  $display("FAIL extra_frame_done dut%0d cyc=%0d got=1 exp=0", d, cyc);
               end else begin
                  int due;
                  due = dq[d].pop_front();
                  if (due != cyc) begin
                     failures++;
                     $display("FAIL frame_done_time dut%0d got cyc=%0d exp cyc=%0d", d, cyc, due);
                  end
               end
            end else begin
               while (dq[d].size() > 0 && dq[d][0] <= cyc) begin
                  checks++;
                  failures++;
                  $display("FAIL missing_frame_done dut%0d cyc=%0d got=0 exp=1", d, cyc);
                  void'(dq[d].pop_front());
               end
            end
         end
      end
   end

   // mode: 0 = continuous pixels k+1, 1 = valid toggling, 2 = random valid
   task automatic run_frame(input int d, input int mode, input int abort_after,
                            input bit noise, input int reset_at);
      int         k;
      int         i;
      bit         v;
      logic [7:0] p;
      logic [7:0] last;
      exp_t       e;
      k    = 0;
      i    = 0;
      last = 8'd0;
      @(negedge clk); st[d] = 1'b1;
      @(negedge clk); st[d] = 1'b0;
      while (k < N) begin
         chk("src_ready_stream", d, rdy[d], 1);
         if (k == abort_after) begin
            ab[d] = 1'b1; sv[d] = 1'b1; sp[d] = 8'hA5;
            @(negedge clk);
            ab[d] = 1'b0; sv[d] = 1'b0;
            chk("busy_after_abort", d, busy[d], 0);
            chk("valid_after_abort", d, pv[d], 0);
            return;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (i % 2) == 0;
            default: v = $urandom_range(1, 0) == 1;
         endcase
         p = (mode == 0) ? 8'(k + 1) : 8'($urandom);
         sv[d] = v;
         sp[d] = p;
         if (noise && k == 5) st[d] = 1'b1;
         if (v) begin
            e.pix = p;
            e.col = CB'(k % W);
            e.row = RB'(k / W);
            e.sof = (k == 0);
            e.eol = (k % W) == W - 1;
            e.eof = (k == N - 1);
            e.fl  = 1'b0;
            e.due = cyc + 1;
            eq[d].push_back(e);
            last = p;
            k++;
         end
         i++;
         @(negedge clk);
         st[d] = 1'b0;
         if (!v && k > 0) chk("pixel_hold", d, pxo[d], last);
      end
      sv[d] = 1'b0;
      chk("src_ready_after_last", d, rdy[d], 0);
      for (int j = 0; j < flush_of(d); j++) begin
         e.pix = 8'd0;
         e.col = CB'(W - 1);
         e.row = RB'(H - 1);
         e.sof = 1'b0; e.eol = 1'b0; e.eof = 1'b0; e.fl = 1'b1;
         e.due = cyc + 1 + j;
         eq[d].push_back(e);
      end
      dq[d].push_back(cyc + 1 + flush_of(d));
      if (reset_at >= 0) begin
         repeat (reset_at) @(negedge clk);
         rst[d] = 1'b1;
         while (eq[d].size() > 0 && eq[d][eq[d].size() - 1].due > cyc) void'(eq[d].pop_back());
         while (dq[d].size() > 0 && dq[d][dq[d].size() - 1] > cyc) void'(dq[d].pop_back());
         @(negedge clk);
         chk("reset_mid_flush_outputs", d,
             {8'd0, pxo[d], 4'(colo[d]), 4'(rowo[d]), pv[d], sofo[d], eolo[d], eofo[d],
              flo[d], busy[d], done[d], rdy[d]}, 0);
         rst[d] = 1'b0;
         return;
      end
      for (int j = 0; j < flush_of(d) + 2; j++) begin
         if (noise && j == 2) st[d] = 1'b1;
         @(negedge clk);
         st[d] = 1'b0;
      end
      chk("busy_after_frame", d, busy[d], 0);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; st[d] = 1'b0; ab[d] = 1'b0; sv[d] = 1'b0; sp[d] = 8'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_state", d,
             {8'd0, pxo[d], 4'(colo[d]), 4'(rowo[d]), pv[d], sofo[d], eolo[d], eofo[d],
              flo[d], busy[d], done[d], rdy[d]}, 0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      mon_en = 1'b1;

      run_frame(0, 0, -1, 1'b0, -1);
      run_frame(0, 1, -1, 1'b0, -1);
      run_frame(0, 2,  7, 1'b0, -1);
      run_frame(0, 0, -1, 1'b0, -1);
      run_frame(0, 2, -1, 1'b1, -1);
      run_frame(0, 2, -1, 1'b1, -1);

      @(negedge clk); st[0] = 1'b1; ab[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0; ab[0] = 1'b0;
      chk("start_abort_idle_busy", 0, busy[0], 0);
      @(negedge clk);
      chk("start_abort_idle_busy_later", 0, busy[0], 0);

      run_frame(0, 0, -1, 1'b0, 2);
      run_frame(0, 2, -1, 1'b0, -1);
      run_frame(1, 0, -1, 1'b0, -1);
      run_frame(1, 2, -1, 1'b0, -1);
      run_frame(1, 2,  3, 1'b0, -1);

      repeat (4) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("scoreboard_drained", d, eq[d].size() + dq[d].size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
